core_run_ctrl: RTL and testbench
================================

// Module: core_run_ctrl
// PURPOSE
//  Run-control sequencer wrapped around RISCv_core. Loads instruction memory from a host port while the core is held in reset.
//  Releases the core and gates its progress with a clock enable. Stops it on ECALL/EBREAK, breakpoint, host request or cycle limit.
//  Supports single-step and resume. Top level ANDs core MemWrite and every core state update (PC, regfile) with core_ce.
// PARAMETERS
//  IMEM_AW     8        instruction-memory word-address width (2**IMEM_AW words)
//  XLEN        32       data/PC width
//  MAX_CYCLES  1000000  run-cycle limit before TIMEOUT halt; 0 = unlimited
// PORTS
//  clk          in   1        clock, single domain
//  rst          in   1        synchronous, active-high reset
//  load_start   in   1        host: enter LOAD (honoured in IDLE only)
//  load_valid   in   1        host: load word valid
//  load_ready   out  1        controller accepts load word (high in LOAD)
//  load_addr    in   IMEM_AW  word address of load word
//  load_data    in   XLEN     load word
//  load_done    in   1        host: end of load, return to IDLE
//  start        in   1        IDLE -> RUN
//  halt_req     in   1        host halt request
//  step         in   1        HALTED: execute exactly one instruction
//  resume       in   1        HALTED -> RUN
//  clear        in   1        HALTED -> IDLE (core reset reasserted)
//  bp_en        in   1        breakpoint enable
//  bp_addr      in   XLEN     breakpoint PC
//  pc           in   XLEN     core PC
//  instr        in   XLEN     instruction currently presented to the core
//  core_rst     out  1        reset to RISCv_core
//  core_ce      out  1        core state-update enable (combinational)
//  imem_we      out  1        instruction-memory write strobe (registered)
//  imem_waddr   out  IMEM_AW  write address (registered)
//  imem_wdata   out  XLEN     write data (registered)
//  run_state    out  3        current state (pkg enum)
//  halt_cause   out  3        last halt cause (pkg enum)
//  retired_cnt  out  32       instructions retired since leaving IDLE; saturates at 0xFFFF_FFFF
// BEHAVIOUR
//  Reset values
//   state=IDLE, core_rst=1, core_ce=1, load_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0.
//   halt_cause=NONE, retired_cnt=0, cycle counter=0.
//  A reset mid-load drops the partial load; imem_we is low at the first edge of reset.
//  IDLE
//   core_rst=1, core_ce=1 so the synchronous core reset takes effect.
//   load_start -> LOAD. start -> RUN; start wins if both are high.
//   Entering RUN clears retired_cnt, the cycle counter and halt_cause.
//  LOAD
//   core_rst=1, load_ready=1. Each load_valid&&load_ready -> next cycle imem_we=1 with latched addr/data (1-cycle latency).
//   load_done -> IDLE. A load_valid in the same cycle as load_done is still written.
//  RUN
//   core_rst=0. Halt hits are evaluated on the current pc/instr, in this priority:
//    instr==32'h0000_0073 -> ECALL
//    instr==32'h0010_0073 -> EBREAK
//    bp_en && pc==bp_addr (not masked) -> BKPT
//    MAX_CYCLES!=0 && cycle counter==MAX_CYCLES -> TIMEOUT
//   On any of these hits: core_ce=0 that cycle (instruction NOT executed), next state HALTED, halt_cause latched.
//   halt_req alone: that instruction executes (core_ce=1), then HALTED with cause HOST.
//   Otherwise core_ce=1, and retired_cnt and the cycle counter increment.
//  HALTED
//   core_rst=0, core_ce=0; PC and regfile frozen.
//   Inputs honoured, in this priority: clear -> IDLE; step -> STEP; resume -> RUN.
//  STEP
//   Exactly one cycle. core_ce=1 unless ECALL/EBREAK is presented. retired_cnt+1.
//   Returns to HALTED with cause STEP, or ECALL/EBREAK if blocked.
//  Breakpoint mask
//   Set on STEP entry and on resume; cleared after the first executed instruction, so a halted breakpoint can be stepped or resumed past.
//  Counters saturate and never wrap. halt_req is ignored outside RUN.
// STRUCTURE
//  Package riscv_run_pkg contains:
//   run_state_e {IDLE, LOAD, RUN, STEP, HALTED}
//   halt_cause_e {NONE=0, ECALL=1, EBREAK=2, BKPT=3, HOST=4, TIMEOUT=5, STEP=6}
//   constants INSTR_ECALL, INSTR_EBREAK
//  One combinational sub-module, run_halt_detect: inputs pc, instr, bp_en, bp_addr, bp_mask, cycle count; outputs hit + prioritised cause.
// TESTING
//  1. Load 4 words at addr 0..3 (one per cycle), load_done -> imem_we high 4 cycles, addr 0..3, data exact; then IDLE, core_rst=1.
//  2. start with instr=0x00000073 at the first PC -> core_ce=0 that cycle, HALTED, halt_cause=ECALL(1), retired_cnt=0.
//  3. bp_en=1, bp_addr=0x10, straight-line code -> halt with pc=0x10, retired_cnt=4, BKPT.
//     Then step -> exactly 1 core_ce pulse, pc=0x14, retired_cnt=5, halt_cause=STEP.
//  4. MAX_CYCLES=8, infinite loop -> HALTED after exactly 8 core_ce cycles, halt_cause=TIMEOUT(5).
//  5. halt_req pulsed at retired_cnt=3 -> that instruction executes, HALTED, retired_cnt=4, HOST.
//     resume -> RUN, counting continues from 4.
//  6. rst asserted during LOAD with load_valid high -> next cycle: IDLE, imem_we=0, counters 0, core_rst=1.

Source files
------------

// File: rtl/riscv_run_pkg.sv
// riscv_run_pkg: run-control state/cause encodings and shared helpers
package riscv_run_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } run_state_e;
  typedef enum logic [2:0] {
    HC_NONE    = 3'd0,
    HC_ECALL   = 3'd1,
    HC_EBREAK  = 3'd2,
    HC_BKPT    = 3'd3,
    HC_HOST    = 3'd4,
    HC_TIMEOUT = 3'd5,
    HC_STEP    = 3'd6
  } halt_cause_e;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/run_halt_detect.sv
// run_halt_detect: prioritised halt-hit detection on the presented pc/instr
module run_halt_detect
  import riscv_run_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  input  logic            bp_en,
  input  logic [XLEN-1:0] bp_addr,
  input  logic            bp_mask,
  input  logic [31:0]     cycle_cnt,
  output logic            hit,
  output halt_cause_e     cause
);
  localparam logic TMO_EN = MAX_CYCLES != 0;
  always_comb begin
    cause = instr == XLEN'(INSTR_ECALL)                      ? HC_ECALL :
            instr == XLEN'(INSTR_EBREAK)                     ? HC_EBREAK :
            bp_en && !bp_mask && pc == bp_addr               ? HC_BKPT :
            TMO_EN && cycle_cnt == 32'(MAX_CYCLES)           ? HC_TIMEOUT : HC_NONE;
    hit = cause != HC_NONE;
  end
endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: load/run/step/halt sequencer gating a RISC-V core via reset and clock enable
module core_run_ctrl
  import riscv_run_pkg::*;
#(
  parameter int IMEM_AW    = 8,
  parameter int XLEN       = 32,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [IMEM_AW-1:0] load_addr,
  input  logic [XLEN-1:0]    load_data,
  input  logic               load_done,
  input  logic               start,
  input  logic               halt_req,
  input  logic               step,
  input  logic               resume,
  input  logic               clear,
  input  logic               bp_en,
  input  logic [XLEN-1:0]    bp_addr,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    instr,
  output logic               core_rst,
  output logic               core_ce,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [XLEN-1:0]    imem_wdata,
  output logic [2:0]         run_state,
  output logic [2:0]         halt_cause,
  output logic [31:0]        retired_cnt
);
  run_state_e         state_q, state_d;
  halt_cause_e        cause_q, cause_d, det_cause;
  logic [31:0]        retired_q, retired_d, cycle_q, cycle_d;
  logic               mask_q, mask_d, we_q, we_d, det_hit;
  logic [IMEM_AW-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic               sys_blk, exec, go, accept;
  run_halt_detect #(.XLEN(XLEN), .MAX_CYCLES(MAX_CYCLES)) u_detect (
    .pc(pc), .instr(instr), .bp_en(bp_en), .bp_addr(bp_addr), .bp_mask(mask_q),
    .cycle_cnt(cycle_q), .hit(det_hit), .cause(det_cause)
  );
  always_comb begin
    sys_blk = det_cause == HC_ECALL || det_cause == HC_EBREAK;
    core_ce = (state_q == ST_IDLE || state_q == ST_LOAD) ? 1'b1 :
              state_q == ST_RUN  ? !det_hit :
              state_q == ST_STEP ? !sys_blk : 1'b0;
    exec    = (state_q == ST_RUN || state_q == ST_STEP) && core_ce;
    go      = state_q == ST_IDLE && start;
    accept  = state_q == ST_LOAD && load_valid;
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = go ? ST_RUN : load_start ? ST_LOAD : ST_IDLE;
      ST_LOAD:   state_d = load_done ? ST_IDLE : ST_LOAD;
      ST_RUN:    state_d = (det_hit || halt_req) ? ST_HALTED : ST_RUN;
      ST_STEP:   state_d = ST_HALTED;
      ST_HALTED: state_d = clear ? ST_IDLE : step ? ST_STEP : resume ? ST_RUN : ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
    cause_d   = go                              ? HC_NONE :
                state_q == ST_RUN && det_hit    ? det_cause :
                state_q == ST_RUN && halt_req   ? HC_HOST :
                state_q == ST_STEP              ? (sys_blk ? det_cause : HC_STEP) : cause_q;
    retired_d = go ? '0 : exec ? sat_inc(retired_q) : retired_q;
    cycle_d   = go ? '0 : (exec && state_q == ST_RUN) ? sat_inc(cycle_q) : cycle_q;
    // mask lets a halted breakpoint be stepped/resumed past; first executed instruction drops it
    mask_d    = go ? 1'b0 :
                (state_q == ST_HALTED && !clear && (step || resume)) ? 1'b1 :
                exec ? 1'b0 : mask_q;
    we_d      = accept;
    waddr_d   = accept ? load_addr : waddr_q;
    wdata_d   = accept ? load_data : wdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cause_q   <= HC_NONE;
      retired_q <= '0;
      cycle_q   <= '0;
      mask_q    <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
      cycle_q   <= cycle_d;
      mask_q    <= mask_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end
  assign core_rst    = state_q == ST_IDLE || state_q == ST_LOAD;
  assign load_ready  = state_q == ST_LOAD;
  assign imem_we     = we_q;
  assign imem_waddr  = waddr_q;
  assign imem_wdata  = wdata_q;
  assign run_state   = state_q;
  assign halt_cause  = cause_q;
  assign retired_cnt = retired_q;
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: scoreboard bench with a tiny core stand-in driving pc/instr
module tb_core_run_ctrl;
  logic        clk = 0, rst = 1;
  logic        load_start = 0, load_valid = 0, load_done = 0, load_ready;
  logic [7:0]  load_addr = 0;
  logic [31:0] load_data = 0;
  logic        start = 0, halt_req = 0, step = 0, resume = 0, clear = 0, bp_en = 0;
  logic [31:0] bp_addr = 0, pc = 0, instr;
  logic        core_rst, core_ce, imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata, retired_cnt;
  logic [2:0]  run_state, halt_cause;
  int          total = 0, bad = 0, ce_cnt = 0, we_cnt = 0, mode = 0;
  logic [39:0] exp_q[$];

  core_run_ctrl #(.IMEM_AW(8), .XLEN(32), .MAX_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data), .load_done(load_done), .start(start),
    .halt_req(halt_req), .step(step), .resume(resume), .clear(clear), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .instr(instr), .core_rst(core_rst), .core_ce(core_ce),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .run_state(run_state),
    .halt_cause(halt_cause), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // mode 0: straight-line NOPs, mode 1: ECALL at pc 0, mode 2: jump-to-self loop
  assign instr = (mode == 1 && pc == 0) ? 32'h0000_0073 : 32'h0000_0013;
  always @(posedge clk)
    if (core_rst) pc <= 0;
    else if (core_ce) pc <= (mode == 2) ? pc : pc + 4;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (core_ce && (run_state == 3'd2 || run_state == 3'd3)) ce_cnt++;
    if (imem_we) begin
      we_cnt++;
      if (exp_q.size() == 0) check("imem_unexpected", 1, 0);
      else check("imem_write", {imem_waddr, imem_wdata}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int n = 0;
    while (run_state != 3'd4 && n < budget) begin tick(); n++; end
    check(tag, run_state, 3'd4);
  endtask

  initial begin
    logic [31:0] d;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    check("rst_state", run_state, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_core_ce", core_ce, 1);
    check("rst_load_ready", load_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_cause", halt_cause, 0);
    check("rst_retired", retired_cnt, 0);
    // 1: load four words, load_done with the last one
    tick();
    load_start = 1; tick(); load_start = 0;
    check("load_ready", load_ready, 1);
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      load_valid = 1; load_addr = 8'(i); load_data = d; load_done = (i == 3);
      exp_q.push_back({8'(i), d});
      tick();
    end
    load_valid = 0; load_done = 0;
    tick(); tick();
    check("load_we_cnt", we_cnt, 4);
    check("load_q_empty", exp_q.size(), 0);
    check("load_idle", run_state, 0);
    check("load_core_rst", core_rst, 1);
    // 2: ECALL at first PC
    mode = 1;
    start = 1; tick(); start = 0;
    @(negedge clk);
    check("ecall_ce", core_ce, 0);
    check("ecall_core_rst", core_rst, 0);
    tick();
    check("ecall_state", run_state, 4);
    check("ecall_cause", halt_cause, 1);
    check("ecall_retired", retired_cnt, 0);
    clear = 1; tick(); clear = 0;
    check("clear_idle", run_state, 0);
    // 3: breakpoint at 0x10 then single-step past it
    mode = 0; bp_en = 1; bp_addr = 32'h10;
    start = 1; tick(); start = 0;
    wait_halted("bkpt_halt", 20);
    check("bkpt_pc", pc, 32'h10);
    check("bkpt_retired", retired_cnt, 4);
    check("bkpt_cause", halt_cause, 3);
    ce_cnt = 0;
    step = 1; tick(); step = 0;
    check("step_state", run_state, 3);
    tick();
    check("step_halted", run_state, 4);
    check("step_ce_cnt", ce_cnt, 1);
    check("step_pc", pc, 32'h14);
    check("step_retired", retired_cnt, 5);
    check("step_cause", halt_cause, 6);
    clear = 1; tick(); clear = 0; bp_en = 0;
    // 4: timeout on a self loop
    mode = 2; ce_cnt = 0;
    start = 1; tick(); start = 0;
    wait_halted("tmo_halt", 30);
    check("tmo_ce_cnt", ce_cnt, 8);
    check("tmo_cause", halt_cause, 5);
    check("tmo_retired", retired_cnt, 8);
    clear = 1; tick(); clear = 0;
    // 5: host halt at retired_cnt 3, then resume
    mode = 0;
    start = 1; tick(); start = 0;
    for (int n = 0; n < 20 && retired_cnt != 3; n++) tick();
    check("host_pre_cnt", retired_cnt, 3);
    halt_req = 1; tick(); halt_req = 0;
    check("host_state", run_state, 4);
    check("host_retired", retired_cnt, 4);
    check("host_cause", halt_cause, 4);
    check("host_pc", pc, 32'h10);
    resume = 1; tick(); resume = 0;
    check("resume_state", run_state, 2);
    tick();
    check("resume_retired", retired_cnt, 5);
    halt_req = 1; tick(); halt_req = 0;
    check("host2_state", run_state, 4);
    check("host2_retired", retired_cnt, 6);
    clear = 1; tick(); clear = 0;
    // 6: reset mid-load with a valid word drops it
    load_start = 1; tick(); load_start = 0;
    load_valid = 1; load_addr = 8'h5; load_data = 32'hdead_beef; rst = 1;
    tick();
    load_valid = 0; rst = 0;
    check("rstload_state", run_state, 0);
    check("rstload_we", imem_we, 0);
    check("rstload_retired", retired_cnt, 0);
    check("rstload_cause", halt_cause, 0);
    check("rstload_core_rst", core_rst, 1);
    tick(); tick();
    check("final_we_cnt", we_cnt, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
